spike_rate_meter: RTL and testbench
===================================

// Module: spike_rate_meter
// PURPOSE
//  Downstream consumer of the network spike_output (OR of synapse outputs).
//  - Counts rising edges of spike_in over fixed windows of WINDOW_CYCLES enabled cycles.
//  - At each window end, publishes a saturated count plus a one-cycle valid pulse.
//  - Drives the 8-bit display bus (uo_out) in the top level.
// PARAMETERS
//  WINDOW_CYCLES  1000  window length in enabled clk cycles; legal range >= 2
//  COUNT_W        8     accumulator/count width; legal range 4..8
// PORTS
//  clk         in   1        single clock, rising edge
//  reset       in   1        synchronous, active-high (top derives it as !rst_n)
//  ena         in   1        count enable; low freezes window timer and accumulator
//  spike_in    in   1        spike train from synapse stage; may be high >1 cycle
//  count_out   out  COUNT_W  count for last completed window
//  rate_valid  out  1        1-cycle pulse when count_out updates
//  overflow    out  1        last completed window saturated
//  seg_out     out  8        display bus; encoding per CONFIGURATION
// BEHAVIOUR
//  Reset: clk and reset are the only clock/reset; reset is synchronous, active-high.
//   On reset, all of the following clear to 0: wcnt, acc, ovf_acc, spike_d,
//   count_out, rate_valid, overflow, seg_out.
//   Reset mid-window discards the partial count; no rate_valid is produced.
//  Edge detect:
//   - spike_d <= spike_in every cycle, regardless of ena.
//   - edge = spike_in & ~spike_d. A held-high spike counts once.
//   - Raising ena while spike_in is high does not create an edge.
//  Window timer: wcnt counts 0..WINDOW_CYCLES-1; it advances only when ena=1.
//   term = ena & (wcnt == WINDOW_CYCLES-1).
//  Accumulate (ena=1, term=0):
//   - If edge, acc <= acc+1, saturating at 2^COUNT_W-1.
//   - If an edge arrives while acc is at max, ovf_acc <= 1.
//  Terminal cycle (term=1), all registered on the same edge:
//   - count_out <= sat(acc + edge); an edge on the terminal cycle belongs to the closing window.
//   - overflow  <= ovf_acc | (edge & acc==max).
//   - rate_valid <= 1.
//   - acc <= 0, ovf_acc <= 0, wcnt <= 0.
//  Latency: rate_valid is high exactly in the cycle after the terminal cycle.
//   All other cycles it is 0. count_out and overflow hold until the next terminal cycle.
//  ena=0: wcnt, acc and ovf_acc hold; edges are ignored (not counted).
//   Outputs hold; rate_valid = 0.
//  Arithmetic: acc is never allowed to wrap; saturation is sticky only within its window.
//  seg_out: registered on the same edge as count_out.
// CONFIGURATION
//  SPIKE_SEG7_EN undefined: seg_out = count_out zero-extended to 8 bits.
//  SPIKE_SEG7_EN defined:
//   - seg_out[6:0] = hex 7-segment code of count_out[3:0]; bit0=a .. bit6=g, active-high.
//     Codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//   - seg_out[7] = overflow (decimal point).
//  Ports and timing are identical in both builds.
// TESTING (bench params WINDOW_CYCLES=16, COUNT_W=4 unless stated)
//  1. Reset, ena=1, 5 single-cycle spikes in window 1
//     -> rate_valid pulses once at cycle 17; count_out=5; overflow=0.
//  2. spike_in held high 6 cycles, then 1-cycle spike on the terminal cycle
//     -> count_out=2; the edge on the terminal cycle is included.
//  3. 20 spikes in one window (every other cycle, WINDOW_CYCLES=64)
//     -> count_out=15; overflow=1. Next window with 3 spikes -> count_out=3; overflow=0.
//  4. ena low for 10 cycles mid-window, with spikes during the gap
//     -> gap spikes are not counted; rate_valid is delayed by exactly 10 cycles.
//  5. reset asserted at wcnt=8 with acc=4
//     -> next cycle all outputs are 0; the following window reports only post-reset spikes.
//  6. Build with SPIKE_SEG7_EN: count 5 -> seg_out=8'h6D; saturated count 15 -> seg_out=8'hF1.
//     Build without the macro: count 5 -> seg_out=8'h05.

Source files
------------

// File: rtl/spike_rate_meter.sv
// -----------------------------------------------------------------------------
// spike_rate_meter
//
// Measures the firing rate of the network spike output. Rising edges of
// spike_in are counted over fixed windows of WINDOW_CYCLES enabled cycles.
// At the end of each window the module publishes:
//   - a saturated count,
//   - an overflow flag,
//   - a display byte,
// and raises rate_valid for exactly one cycle.
//
// Optional feature macro: SPIKE_SEG7_EN
//   undefined : seg_out = count_out zero-extended to 8 bits
//   defined   : seg_out[6:0] = hex 7-segment code of count_out[3:0]
//               (bit0 = a .. bit6 = g, active-high)
//               seg_out[7]   = overflow, shown as the decimal point
//
// Parameters
//   WINDOW_CYCLES  window length in enabled clk cycles (>= 2)
//   COUNT_W        accumulator / count width (4..8)
//
// Ports
//   clk         in   1        single clock, rising edge
//   reset       in   1        synchronous, active-high
//   ena         in   1        count enable; low freezes timer and accumulator
//   spike_in    in   1        spike train; may stay high for several cycles
//   count_out   out  COUNT_W  count for the last completed window
//   rate_valid  out  1        one-cycle pulse when count_out updates
//   overflow    out  1        last completed window saturated
//   seg_out     out  8        display bus
// -----------------------------------------------------------------------------
module spike_rate_meter #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic               spike_in,
  output logic [COUNT_W-1:0] count_out,
  output logic               rate_valid,
  output logic               overflow,
  output logic [7:0]         seg_out
);

  localparam int                 WCNT_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WCNT_W-1:0]  WLAST  = WCNT_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CMAX   = '1;

  logic [WCNT_W-1:0]  r_wcnt;
  logic [COUNT_W-1:0] r_acc;
  logic               r_ovf_acc;
  logic               r_spike_d;

  logic               w_edge;
  logic               w_term;
  logic               w_at_max;
  logic [COUNT_W-1:0] w_close_cnt;
  logic               w_close_ovf;

  // Saturating increment: the accumulator sticks at its maximum value and
  // never wraps.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == CMAX) ? v : v + COUNT_W'(1);
  endfunction

  // Display encoding, computed from the values being published so that
  // seg_out lands on the same edge as count_out and overflow.
  function automatic logic [7:0] seg_enc(input logic [COUNT_W-1:0] c, input logic ov);
`ifdef SPIKE_SEG7_EN
    logic [6:0] s;
    case (c[3:0])
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return {ov, s};
`else
    logic unused_ov;
    unused_ov = ov;
    return 8'(c);
`endif
  endfunction

  // spike_d tracks spike_in even while ena is low, so raising ena while
  // spike_in is already high does not create an edge.
  assign w_edge      = spike_in & ~r_spike_d;
  assign w_term      = ena & (r_wcnt == WLAST);
  assign w_at_max    = (r_acc == CMAX);

  // An edge on the terminal cycle belongs to the window that is closing.
  assign w_close_cnt = w_edge ? sat_inc(r_acc) : r_acc;
  assign w_close_ovf = r_ovf_acc | (w_edge & w_at_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt     <= '0;
      r_acc      <= '0;
      r_ovf_acc  <= 1'b0;
      r_spike_d  <= 1'b0;
      count_out  <= '0;
      rate_valid <= 1'b0;
      overflow   <= 1'b0;
      seg_out    <= 8'h00;
    end else begin
      r_spike_d  <= spike_in;
      rate_valid <= 1'b0;
      if (w_term) begin
        count_out  <= w_close_cnt;
        overflow   <= w_close_ovf;
        seg_out    <= seg_enc(w_close_cnt, w_close_ovf);
        rate_valid <= 1'b1;
        r_acc      <= '0;
        r_ovf_acc  <= 1'b0;
        r_wcnt     <= '0;
      end else if (ena) begin
        r_wcnt <= r_wcnt + WCNT_W'(1);
        if (w_edge) begin
          r_acc <= sat_inc(r_acc);
          if (w_at_max) begin
            r_ovf_acc <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_meter.sv
module tb_spike_rate_meter;

  localparam int CW = 4;

`ifdef SPIKE_SEG7_EN
  localparam logic [7:0] SEG_5    = 8'h6D;
  localparam logic [7:0] SEG_2    = 8'h5B;
  localparam logic [7:0] SEG_3    = 8'h4F;
  localparam logic [7:0] SEG_15OV = 8'hF1;
`else
  localparam logic [7:0] SEG_5    = 8'h05;
  localparam logic [7:0] SEG_2    = 8'h02;
  localparam logic [7:0] SEG_3    = 8'h03;
  localparam logic [7:0] SEG_15OV = 8'h0F;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ena = 1'b0;
  logic          spike_in = 1'b0;
  logic [CW-1:0] cnt16, cnt64;
  logic          rv16, rv64, ov16, ov64;
  logic [7:0]    seg16, seg64;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = 0;

  always #5 clk = ~clk;

  spike_rate_meter #(.WINDOW_CYCLES(16), .COUNT_W(CW)) dut16 (
    .clk(clk), .reset(reset), .ena(ena), .spike_in(spike_in),
    .count_out(cnt16), .rate_valid(rv16), .overflow(ov16), .seg_out(seg16)
  );

  spike_rate_meter #(.WINDOW_CYCLES(64), .COUNT_W(CW)) dut64 (
    .clk(clk), .reset(reset), .ena(ena), .spike_in(spike_in),
    .count_out(cnt64), .rate_valid(rv64), .overflow(ov64), .seg_out(seg64)
  );

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  // cyc = index of the edge just taken; a pulse seen after edge k is in cycle k+1.
  task automatic step(input logic en, input logic sp);
    ena = en;
    spike_in = sp;
    @(posedge clk);
    #1;
    cyc++;
    if (rv16) begin
      pulses++;
      pulse_cyc = cyc + 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    reset = 1'b0;
    cyc = 0;
    pulses = 0;
    pulse_cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cnt16 !== 4'd0) begin errors++; $display("FAIL reset_count got=%0h exp=0", cnt16); end
    checks++; if (rv16 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", rv16); end
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", ov16); end
    checks++; if (seg16 !== 8'h00) begin errors++; $display("FAIL reset_seg got=%02h exp=00", seg16); end
    checks++; if (cnt64 !== 4'd0 || rv64 !== 1'b0 || ov64 !== 1'b0 || seg64 !== 8'h00) begin
      errors++; $display("FAIL reset_dut64 got=%0h/%0b/%0b/%02h exp=0/0/0/00", cnt64, rv64, ov64, seg64);
    end
  endtask

  task automatic test_basic_count();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, (k >= 2 && k <= 10 && (k % 2 == 0)));
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL basic_pulses got=%0d exp=1", pulses); end
    checks++; if (pulse_cyc !== 17) begin errors++; $display("FAIL basic_latency got=%0d exp=17", pulse_cyc); end
    checks++; if (cnt16 !== 4'd5) begin errors++; $display("FAIL basic_count got=%0d exp=5", cnt16); end
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%0b exp=0", ov16); end
    checks++; if (seg16 !== SEG_5) begin errors++; $display("FAIL basic_seg got=%02h exp=%02h", seg16, SEG_5); end
  endtask

  task automatic test_held_and_terminal_edge();
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      step(1'b1, ((k >= 3 && k <= 8) || k == 16));
      if (k == 15) begin
        checks++; if (rv16 !== 1'b0) begin errors++; $display("FAIL term_early_valid got=%0b exp=0", rv16); end
      end
      if (k == 16) begin
        checks++; if (rv16 !== 1'b1) begin errors++; $display("FAIL term_valid got=%0b exp=1", rv16); end
        checks++; if (cnt16 !== 4'd2) begin errors++; $display("FAIL term_count got=%0d exp=2", cnt16); end
      end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL term_pulses got=%0d exp=1", pulses); end
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL term_ovf got=%0b exp=0", ov16); end
    checks++; if (seg16 !== SEG_2) begin errors++; $display("FAIL term_seg got=%02h exp=%02h", seg16, SEG_2); end
  endtask

  task automatic test_saturation();
    int early;
    early = 0;
    do_reset();
    for (int k = 1; k <= 128; k++) begin
      step(1'b1, ((k <= 40 && (k % 2 == 0)) || k == 66 || k == 68 || k == 70));
      if (k < 64 && rv64) early++;
      if (k == 64) begin
        checks++; if (rv64 !== 1'b1) begin errors++; $display("FAIL sat_valid got=%0b exp=1", rv64); end
        checks++; if (cnt64 !== 4'd15) begin errors++; $display("FAIL sat_count got=%0d exp=15", cnt64); end
        checks++; if (ov64 !== 1'b1) begin errors++; $display("FAIL sat_ovf got=%0b exp=1", ov64); end
        checks++; if (seg64 !== SEG_15OV) begin errors++; $display("FAIL sat_seg got=%02h exp=%02h", seg64, SEG_15OV); end
      end
      if (k == 65) begin
        checks++; if (rv64 !== 1'b0) begin errors++; $display("FAIL sat_valid_drop got=%0b exp=0", rv64); end
      end
      if (k == 128) begin
        checks++; if (rv64 !== 1'b1) begin errors++; $display("FAIL sat_next_valid got=%0b exp=1", rv64); end
        checks++; if (cnt64 !== 4'd3) begin errors++; $display("FAIL sat_next_count got=%0d exp=3", cnt64); end
        checks++; if (ov64 !== 1'b0) begin errors++; $display("FAIL sat_next_ovf got=%0b exp=0", ov64); end
        checks++; if (seg64 !== SEG_3) begin errors++; $display("FAIL sat_next_seg got=%02h exp=%02h", seg64, SEG_3); end
      end
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL sat_early_pulse got=%0d exp=0", early); end
  endtask

  task automatic test_ena_gap();
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      step(!(k >= 6 && k <= 15),
           (k == 2 || k == 7 || k == 9 || k == 15 || k == 16 || k == 20));
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL gap_pulses got=%0d exp=1", pulses); end
    checks++; if (pulse_cyc !== 27) begin errors++; $display("FAIL gap_latency got=%0d exp=27", pulse_cyc); end
    checks++; if (cnt16 !== 4'd2) begin errors++; $display("FAIL gap_count got=%0d exp=2", cnt16); end
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL gap_ovf got=%0b exp=0", ov16); end
  endtask

  task automatic test_mid_window_reset();
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      step(1'b1, (k == 2 || k == 5 || k == 9 || (k >= 17 && k <= 23 && (k % 2 == 1))));
    end
    checks++; if (cnt16 !== 4'd3) begin errors++; $display("FAIL mid_prior_count got=%0d exp=3", cnt16); end
    reset = 1'b1;
    step(1'b1, 1'b0);
    reset = 1'b0;
    checks++; if (cnt16 !== 4'd0) begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", cnt16); end
    checks++; if (rv16 !== 1'b0 || ov16 !== 1'b0) begin
      errors++; $display("FAIL mid_rst_flags got=%0b/%0b exp=0/0", rv16, ov16);
    end
    checks++; if (seg16 !== 8'h00) begin errors++; $display("FAIL mid_rst_seg got=%02h exp=00", seg16); end
    cyc = 0;
    pulses = 0;
    pulse_cyc = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, (k == 2 || k == 4));
    end
    checks++; if (pulses !== 1 || pulse_cyc !== 17) begin
      errors++; $display("FAIL mid_post_pulse got=%0d@%0d exp=1@17", pulses, pulse_cyc);
    end
    checks++; if (cnt16 !== 4'd2) begin errors++; $display("FAIL mid_post_count got=%0d exp=2", cnt16); end
    checks++; if (seg16 !== SEG_2) begin errors++; $display("FAIL mid_post_seg got=%02h exp=%02h", seg16, SEG_2); end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_held_and_terminal_edge();
    test_saturation();
    test_ena_gap();
    test_mid_window_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
